// File: rtl/search_data_feeder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | search_data_feeder_if                                                |
// | Memory read port plus current-row and reference-beat output streams  |
// | of the search data feeder.                                           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface search_data_feeder_if;
  logic         mem_rd_req;
  logic [19:0]  mem_rd_addr;
  logic         mem_rd_gnt;
  logic         mem_rd_valid;
  logic [511:0] mem_rd_data;
  logic [511:0] current_64pixels;
  logic         in_curr_enable;
  logic [255:0] ref_input;
  logic         ref_valid;
  logic         ref_ready;

  // The feeder side
  modport master (
    output mem_rd_req, mem_rd_addr, current_64pixels, in_curr_enable,
           ref_input, ref_valid,
    input  mem_rd_gnt, mem_rd_valid, mem_rd_data, ref_ready
  );

  // Memory / PE array / reference memory side
  modport slave (
    input  mem_rd_req, mem_rd_addr, current_64pixels, in_curr_enable,
           ref_input, ref_valid,
    output mem_rd_gnt, mem_rd_valid, mem_rd_data, ref_ready
  );
endinterface
`default_nettype wire

// File: rtl/search_data_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | search_data_feeder                                                   |
// | Fetches CUR_ROWS current-block rows (streamed straight to the PE     |
// | array) then REF_WORDS reference words (buffered, split into two      |
// | 256-bit beats each) with credit-limited outstanding reads.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module search_data_feeder #(
  parameter int CUR_ROWS   = 64,
  parameter int REF_WORDS  = 96,
  parameter int FIFO_DEPTH = 4
) (
  input  wire        clk,
  input  wire        rst_n,
  input  wire        start,
  input  wire [19:0] cur_base,
  input  wire [19:0] ref_base,
  input  wire [11:0] stride,
  output logic       busy,
  output logic       done,
  search_data_feeder_if.master bus
);

  localparam int c_PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CW   = $clog2(FIFO_DEPTH + 1);
  localparam int c_MAXN = (CUR_ROWS > REF_WORDS) ? CUR_ROWS : REF_WORDS;
  localparam int c_RW   = $clog2(c_MAXN + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CUR   = 2'd1,
    ST_REF   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t            r_state;
  logic [19:0]       r_addr;
  logic [19:0]       r_ref_base;
  logic [11:0]       r_stride;
  logic [c_RW-1:0]   r_req_cnt;
  logic [c_CW-1:0]   r_out;      // granted reads not yet returned
  logic [c_CW-1:0]   r_cur_out;  // of those, how many belong to the CUR phase
  logic [c_CW-1:0]   r_count;    // FIFO occupancy in words
  logic [c_PW-1:0]   r_wr_ptr;
  logic [c_PW-1:0]   r_rd_ptr;
  logic              r_half;     // 0: presenting low half of head word
  logic [511:0]      r_cur_data;
  logic              r_cur_en;
  logic              r_done;
  logic [511:0]      r_fifo [FIFO_DEPTH];

  logic w_active, w_credit, w_req, w_grant;
  logic w_ret, w_ret_cur, w_push, w_ref_valid, w_beat, w_pop, w_last;

  function automatic logic [c_PW-1:0] f_ptr_inc(input logic [c_PW-1:0] p);
    return (p == c_PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Reads are issued only while the returns they produce are guaranteed a
  // slot; since the credit sum cannot grow without a grant, a raised request
  // stays raised with a stable address until it is granted.
  assign w_active    = (r_state == ST_CUR) || (r_state == ST_REF);
  assign w_credit    = ({1'b0, r_out} + {1'b0, r_count}) < (c_CW + 1)'(FIFO_DEPTH);
  assign w_req       = w_active && w_credit;
  assign w_grant     = w_req && bus.mem_rd_gnt;
  // Returns arrive in request order, so the first r_cur_out of them are rows.
  // A return with nothing outstanding is stale (e.g. issued before a reset).
  assign w_ret       = bus.mem_rd_valid && (r_out != '0);
  assign w_ret_cur   = w_ret && (r_cur_out != '0);
  assign w_push      = w_ret && (r_cur_out == '0);
  assign w_ref_valid = (r_count != '0);
  assign w_beat      = w_ref_valid && bus.ref_ready;
  assign w_pop       = w_beat && r_half;
  assign w_last      = w_pop && (r_state == ST_DRAIN) && (r_out == '0) &&
                       (r_count == c_CW'(1));

  assign bus.mem_rd_req       = w_req;
  assign bus.mem_rd_addr      = r_addr;
  assign bus.current_64pixels = r_cur_data;
  assign bus.in_curr_enable   = r_cur_en;
  assign bus.ref_valid        = w_ref_valid;
  assign bus.ref_input        = !w_ref_valid ? '0 :
                                r_half ? r_fifo[r_rd_ptr][511:256] : r_fifo[r_rd_ptr][255:0];
  assign busy                 = (r_state != ST_IDLE);
  assign done                 = r_done;

  // Phase sequencing, per-phase request counting and address generation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_ref_base <= '0;
      r_stride   <= '0;
      r_req_cnt  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_last;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_CUR;
            r_addr     <= cur_base;
            r_ref_base <= ref_base;
            r_stride   <= stride;
            r_req_cnt  <= '0;
          end
        end
        ST_CUR: begin
          if (w_grant) begin
            if (r_req_cnt == c_RW'(CUR_ROWS - 1)) begin
              r_state   <= ST_REF;
              r_req_cnt <= '0;
              r_addr    <= r_ref_base;
            end else begin
              r_req_cnt <= r_req_cnt + 1'b1;
              r_addr    <= r_addr + {8'd0, r_stride};
            end
          end
        end
        ST_REF: begin
          if (w_grant) begin
            if (r_req_cnt == c_RW'(REF_WORDS - 1)) begin
              r_state   <= ST_DRAIN;
              r_req_cnt <= '0;
            end else begin
              r_req_cnt <= r_req_cnt + 1'b1;
              r_addr    <= r_addr + {8'd0, r_stride};
            end
          end
        end
        default: begin
          if (w_last) r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outstanding-read bookkeeping, total and CUR-phase share
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out     <= '0;
      r_cur_out <= '0;
    end else begin
      case ({w_grant, w_ret})
        2'b10:   r_out <= r_out + 1'b1;
        2'b01:   r_out <= r_out - 1'b1;
        default: ;
      endcase
      case ({w_grant && (r_state == ST_CUR), w_ret_cur})
        2'b10:   r_cur_out <= r_cur_out + 1'b1;
        2'b01:   r_cur_out <= r_cur_out - 1'b1;
        default: ;
      endcase
    end
  end

  // Reference FIFO pointers, occupancy and half-word select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_half   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= f_ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_ptr_inc(r_rd_ptr);
      if (w_beat) r_half   <= ~r_half;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  // Reference word storage; occupancy gates the outputs so no reset needed
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= bus.mem_rd_data;
  end

  // Current rows bypass the FIFO with a single register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_data <= '0;
      r_cur_en   <= 1'b0;
    end else begin
      r_cur_en <= w_ret_cur;
      if (w_ret_cur) r_cur_data <= bus.mem_rd_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_search_data_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_search_data_feeder                                                |
// | Memory/consumer model with expected-result queues for the feeder.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_search_data_feeder;
  localparam int CUR_ROWS   = 64;
  localparam int REF_WORDS  = 96;
  localparam int FIFO_DEPTH = 4;

  typedef struct {
    logic [19:0] cur_base;
    logic [19:0] ref_base;
    logic [11:0] stride;
    bit          rand_gnt;
    int          lat_lo;
    int          lat_hi;
    bit          rand_ready;
    bit          restart;
    logic [19:0] exp_last_cur;
    logic [19:0] exp_last_ref;
  } vec_t;

  typedef struct {
    logic [19:0] addr;
    logic [3:0]  seed;
    int          due;
  } pend_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [19:0] cur_base = '0;
  logic [19:0] ref_base = '0;
  logic [11:0] stride = '0;
  logic        busy, done;

  search_data_feeder_if bus_if();

  search_data_feeder #(
    .CUR_ROWS(CUR_ROWS), .REF_WORDS(REF_WORDS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cur_base(cur_base),
    .ref_base(ref_base), .stride(stride), .busy(busy), .done(done),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  logic [19:0]  exp_addr[$];
  logic [511:0] exp_cur[$];
  logic [255:0] exp_beat[$];
  pend_t        pend[$];

  int n_chk = 0, n_err = 0;
  int cyc = 0, g_idx = 0, rows = 0, beats = 0, done_cnt = 0, last_due = 0;
  int lat_lo = 2, lat_hi = 2;
  bit rand_gnt = 0, rand_ready = 0, stall = 0, prev_hold = 0;
  logic [3:0]   seed = '0;
  logic [19:0]  last_cur = '0, last_ref = '0;
  logic [255:0] prev_beat = '0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] word_of(input logic [19:0] a, input logic [3:0] s);
    logic [511:0] w;
    for (int i = 0; i < 16; i++) w[32*i +: 32] = {s, 4'(i), 4'h0, a};
    return w;
  endfunction

  task automatic load_expect(input logic [19:0] cb, input logic [19:0] rb,
                             input logic [11:0] st, input logic [3:0] sd);
    logic [31:0]  t;
    logic [511:0] w;
    exp_addr.delete(); exp_cur.delete(); exp_beat.delete();
    for (int n = 0; n < CUR_ROWS; n++) begin
      t = {12'd0, cb} + 32'(n) * {20'd0, st};
      exp_addr.push_back(t[19:0]);
      exp_cur.push_back(word_of(t[19:0], sd));
    end
    for (int n = 0; n < REF_WORDS; n++) begin
      t = {12'd0, rb} + 32'(n) * {20'd0, st};
      w = word_of(t[19:0], sd);
      exp_addr.push_back(t[19:0]);
      exp_beat.push_back(w[255:0]);
      exp_beat.push_back(w[511:256]);
    end
  endtask

  // Memory, PE-array and reference-consumer model; samples DUT outputs on the
  // falling edge (they depend only on DUT registers) and then drives inputs.
  always @(negedge clk) begin
    pend_t p;
    logic [19:0] a;
    int lat, due;
    bit g, rdy;
    cyc++;
    if (!rst_n) begin
      bus_if.mem_rd_gnt   = 1'b0;
      bus_if.mem_rd_valid = 1'b0;
      bus_if.mem_rd_data  = '0;
      bus_if.ref_ready    = 1'b0;
      prev_hold = 0;
    end else begin
      if (bus_if.in_curr_enable) begin
        rows++;
        if (exp_cur.size() == 0) chk_int("cur_extra_row", 1, 0);
        else chk("cur_row", bus_if.current_64pixels, exp_cur.pop_front());
      end
      if (done) begin
        done_cnt++;
        chk_int("busy_with_done", int'(busy), 0);
      end
      if (prev_hold) begin
        chk_int("ref_hold_valid", int'(bus_if.ref_valid), 1);
        chk("ref_hold_data", {256'd0, bus_if.ref_input}, {256'd0, prev_beat});
      end
      // grant decision; the handshake completes at the next rising edge
      g = rand_gnt ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (bus_if.mem_rd_req && g) begin
        if (exp_addr.size() == 0) chk_int("extra_req", 1, 0);
        else begin
          a = exp_addr.pop_front();
          chk_int("rd_addr", int'(bus_if.mem_rd_addr), int'(a));
        end
        if (g_idx == CUR_ROWS - 1) last_cur = bus_if.mem_rd_addr;
        if (g_idx == CUR_ROWS + REF_WORDS - 1) last_ref = bus_if.mem_rd_addr;
        g_idx++;
        lat = lat_lo + int'($urandom_range(0, lat_hi - lat_lo));
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        p.addr = bus_if.mem_rd_addr; p.seed = seed; p.due = due;
        pend.push_back(p);
      end
      bus_if.mem_rd_gnt = g;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        p = pend.pop_front();
        bus_if.mem_rd_valid = 1'b1;
        bus_if.mem_rd_data  = word_of(p.addr, p.seed);
      end else begin
        bus_if.mem_rd_valid = 1'b0;
        bus_if.mem_rd_data  = {16{32'hDEADBEEF}};
      end
      rdy = stall ? 1'b0 : (rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1);
      if (bus_if.ref_valid && rdy) begin
        beats++;
        if (exp_beat.size() == 0) chk_int("extra_beat", 1, 0);
        else chk("ref_beat", {256'd0, bus_if.ref_input}, {256'd0, exp_beat.pop_front()});
      end
      prev_hold = bus_if.ref_valid && !rdy;
      prev_beat = bus_if.ref_input;
      bus_if.ref_ready = rdy;
    end
  end

  task automatic check_all_zero(input string tag);
    chk_int({tag, "_req"},    int'(bus_if.mem_rd_req), 0);
    chk_int({tag, "_addr"},   int'(bus_if.mem_rd_addr), 0);
    chk    ({tag, "_cur"},    bus_if.current_64pixels, '0);
    chk_int({tag, "_cur_en"}, int'(bus_if.in_curr_enable), 0);
    chk    ({tag, "_ref"},    {256'd0, bus_if.ref_input}, '0);
    chk_int({tag, "_ref_v"},  int'(bus_if.ref_valid), 0);
    chk_int({tag, "_busy"},   int'(busy), 0);
    chk_int({tag, "_done"},   int'(done), 0);
  endtask

  task automatic begin_search(input vec_t v, input logic [3:0] sd);
    rand_gnt = v.rand_gnt; lat_lo = v.lat_lo; lat_hi = v.lat_hi;
    rand_ready = v.rand_ready; seed = sd;
    load_expect(v.cur_base, v.ref_base, v.stride, sd);
    g_idx = 0; rows = 0; beats = 0; done_cnt = 0;
    @(negedge clk);
    cur_base = v.cur_base; ref_base = v.ref_base; stride = v.stride; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_int("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_done(input vec_t v);
    int t = 0;
    while (done_cnt == 0 && t < 8000) begin
      @(negedge clk);
      t++;
      if (v.restart && busy && (t == 5 || t == 120)) begin
        start = 1'b1; cur_base = 20'hAAAAA; ref_base = 20'h55555; stride = 12'hFFF;
      end else start = 1'b0;
    end
    start = 1'b0;
    chk_int("done_seen", int'(done_cnt != 0), 1);
    repeat (4) @(negedge clk);
    chk_int("done_once", done_cnt, 1);
    chk_int("busy_idle", int'(busy), 0);
    chk_int("row_count", rows, CUR_ROWS);
    chk_int("beat_count", beats, 2 * REF_WORDS);
    chk_int("addr_left", exp_addr.size(), 0);
    chk_int("cur_left", exp_cur.size(), 0);
    chk_int("beat_left", exp_beat.size(), 0);
    chk_int("last_cur_addr", int'(last_cur), int'(v.exp_last_cur));
    chk_int("last_ref_addr", int'(last_ref), int'(v.exp_last_ref));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[4];
    vec_t vs;
    int t;
    int g1;
    tbl[0] = '{cur_base:20'h00100, ref_base:20'h02000, stride:12'h004, rand_gnt:0,
               lat_lo:2, lat_hi:2, rand_ready:0, restart:0,
               exp_last_cur:20'h001FC, exp_last_ref:20'h0217C};
    tbl[1] = '{cur_base:20'h00500, ref_base:20'hFFFF0, stride:12'h010, rand_gnt:0,
               lat_lo:2, lat_hi:2, rand_ready:0, restart:0,
               exp_last_cur:20'h008F0, exp_last_ref:20'h005E0};
    tbl[2] = '{cur_base:20'hFFF00, ref_base:20'h40000, stride:12'hABC, rand_gnt:1,
               lat_lo:1, lat_hi:8, rand_ready:1, restart:0,
               exp_last_cur:20'h2A344, exp_last_ref:20'h7FBC4};
    tbl[3] = '{cur_base:20'h12345, ref_base:20'h54321, stride:12'h001, rand_gnt:0,
               lat_lo:2, lat_hi:2, rand_ready:1, restart:1,
               exp_last_cur:20'h12384, exp_last_ref:20'h54380};

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      begin_search(tbl[i], 4'(i + 1));
      wait_done(tbl[i]);
    end

    // consumer stalls for 20 cycles in the middle of the REF phase
    vs = '{cur_base:20'h03000, ref_base:20'h80000, stride:12'h020, rand_gnt:0,
           lat_lo:2, lat_hi:2, rand_ready:0, restart:0,
           exp_last_cur:20'h037E0, exp_last_ref:20'h80BE0};
    begin_search(vs, 4'd5);
    for (t = 0; t < 3000 && g_idx < CUR_ROWS + 8; t++) @(negedge clk);
    chk_int("stall_reach_ref", int'(g_idx >= CUR_ROWS + 8), 1);
    stall = 1;
    repeat (18) @(negedge clk);
    g1 = g_idx;
    repeat (2) @(negedge clk);
    chk_int("stall_req_low", int'(bus_if.mem_rd_req), 0);
    chk_int("stall_ref_valid", int'(bus_if.ref_valid), 1);
    chk_int("stall_no_grants", g_idx, g1);
    stall = 0;
    wait_done(vs);

    // asynchronous reset in the middle of the REF phase, then a clean reload
    begin_search(tbl[0], 4'd6);
    for (t = 0; t < 3000 && g_idx < CUR_ROWS + 20; t++) @(negedge clk);
    chk_int("rst_reach_ref", int'(g_idx >= CUR_ROWS + 20), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    exp_addr.delete(); exp_cur.delete(); exp_beat.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (t = 0; t < 200 && pend.size() != 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk_int("stale_drained", pend.size(), 0);
    chk_int("stale_busy", int'(busy), 0);
    chk_int("stale_ref_valid", int'(bus_if.ref_valid), 0);
    begin_search(tbl[0], 4'd7);
    wait_done(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/search_data_feeder.md
SEARCH_DATA_FEEDER -- requirements
Module: search_data_feeder

Interface
REQ-001 SHALL have parameter CUR_ROWS, default 64, number of 512-bit current-block rows per search.
REQ-002 SHALL have parameter REF_WORDS, default 96, number of 512-bit reference words per search; each word yields two 256-bit ref beats.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, return-data buffer depth and maximum outstanding reads.
REQ-004 SHALL have port clk, input, 1, sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, one-cycle request to begin a search load; ignored unless idle.
REQ-007 SHALL have port cur_base, input, 20, word address of current-block row 0.
REQ-008 SHALL have port ref_base, input, 20, word address of reference word 0.
REQ-009 SHALL have port stride, input, 12, word-address increment between successive rows/words.
REQ-010 SHALL have port mem_rd_req, output, 1, memory read request.
REQ-011 SHALL have port mem_rd_addr, output, 20, memory read address.
REQ-012 SHALL have port mem_rd_gnt, input, 1, request accepted this cycle.
REQ-013 SHALL have port mem_rd_valid, input, 1, read data returned this cycle, in request order.
REQ-014 SHALL have port mem_rd_data, input, 512, returned word.
REQ-015 SHALL have port current_64pixels, output, 512, current-block row to PE array.
REQ-016 SHALL have port in_curr_enable, output, 1, current_64pixels valid this cycle.
REQ-017 SHALL have port ref_input, output, 256, reference beat to reference memory.
REQ-018 SHALL have port ref_valid, output, 1, ref_input valid.
REQ-019 SHALL have port ref_ready, input, 1, consumer accepts ref beat.
REQ-020 SHALL have ports busy and done, outputs, 1 each: load in progress; one-cycle completion pulse.

Function
REQ-021 SHALL implement states IDLE, CUR, REF, DRAIN; IDLE->CUR on start; CUR->REF after CUR_ROWS requests granted; REF->DRAIN after REF_WORDS requests granted; DRAIN->IDLE when last ref beat accepted, pulsing done that cycle.
REQ-022 SHALL latch cur_base, ref_base, stride on accepted start; later input changes have no effect until next start.
REQ-023 SHALL issue request n of each phase at base + n*stride, modulo 2^20 (address wrap, no error).
REQ-024 SHALL assert mem_rd_req only when outstanding reads plus FIFO occupancy < FIFO_DEPTH; hold mem_rd_addr stable until mem_rd_gnt.
REQ-025 SHALL never drop returned data; mem_rd_valid with full FIFO cannot occur given REQ-024.
REQ-026 CUR-phase data SHALL bypass the FIFO: current_64pixels registered from mem_rd_data, in_curr_enable high exactly one cycle after each CUR-phase mem_rd_valid; no backpressure.
REQ-027 REF-phase data SHALL enter the FIFO; FIFO head presented as ref_input = word[255:0] first, then word[511:256]; word popped when upper half accepted.
REQ-028 A beat SHALL transfer only when ref_valid and ref_ready both high; ref_input/ref_valid SHALL hold while ref_valid high and ref_ready low.
REQ-029 Simultaneous FIFO push and pop SHALL keep occupancy unchanged and both succeed.
REQ-030 Phase of each return SHALL be tracked per request so CUR returns arriving after REF requests issue are still routed to current_64pixels.
REQ-031 busy SHALL be high in every state except IDLE; start while busy SHALL be ignored.
REQ-032 Total ref beats per search SHALL equal 2*REF_WORDS; in_curr_enable pulses SHALL equal CUR_ROWS.

Reset
REQ-033 On rst_n low, asynchronously: state IDLE, counters, outstanding count and FIFO cleared; mem_rd_req, in_curr_enable, ref_valid, busy, done = 0; mem_rd_addr, current_64pixels, ref_input = 0.
REQ-034 Reset mid-load SHALL abandon the load; mem_rd_valid returns after reset release without outstanding requests SHALL be discarded.

Verification
REQ-035 start, cur_base=0x100, stride=4, gnt always 1, valid 2 cycles later -> addresses 0x100,0x104..0x1FC; 64 in_curr_enable pulses, data matching.
REQ-036 ref_base=0xFFFF0, stride=0x10 -> address wraps to 0x00000 after 0xFFFF0; no stall.
REQ-037 ref_ready low 20 cycles during REF -> mem_rd_req drops once 4 words held; ref_input held stable; no data lost; 192 beats total in order low/high.
REQ-038 Random gnt/valid latency 1-8 cycles and random ref_ready -> all beats match golden sequence; done pulses once, busy falls same cycle.
REQ-039 rst_n low midway through REF phase -> all outputs 0 next edge-independent; new start loads full sequence correctly.
REQ-040 start asserted while busy -> ignored; latched bases unchanged.
